symbol_feeder: RTL
==================

# symbol_feeder

Upstream input stage of the Aho-Corasick matcher. Accepts text bytes over a valid/ready handshake and buffers them in a small synchronous FIFO. Splits each byte into two 4-bit symbols, high nibble first, and issues them one at a time on `STRING`/`EN` to the table reader, waiting for the reader's per-symbol acknowledge before issuing the next. Also generates the `INITIALIZE` pulse at start of text and a symbol position count for match reporting.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `CNT_W`, 16, width of `SYM_COUNT`
- `CLK` in 1 — single clock, all logic rising-edge
- `RST` in 1 — synchronous, active-high reset
- `IN_VALID` in 1 — input byte valid
- `IN_READY` out 1 — FIFO can accept; equals `!full`, registered-state only (no path from `SYM_ACK`)
- `IN_DATA` in 8 — text byte
- `IN_SOT` in 1 — byte is first of a new text
- `IN_EOT` in 1 — byte is last of the text
- `EN` out 1 — one-cycle pulse: `STRING` holds a new symbol
- `STRING` out 4 — symbol to table reader
- `INITIALIZE` out 1 — one-cycle pulse: reset matcher to root state
- `SYM_ACK` in 1 — table reader finished current symbol (driven by reader's `EN_MATCH`)
- `SYM_COUNT` out CNT_W — symbols acknowledged since last `INITIALIZE`
- `DONE` out 1 — one-cycle pulse after last symbol of an EOT byte is acknowledged
- `BUSY` out 1 — FSM not in S_IDLE or FIFO non-empty

## Operation
- Push: `IN_VALID && IN_READY` writes {SOT, EOT, byte} (10 bits) into the FIFO. `IN_VALID` while full is not accepted; the source must hold the byte.
- Issue FSM states: S_IDLE, S_INIT, S_HI_ISSUE, S_HI_WAIT, S_LO_ISSUE, S_LO_WAIT.
- S_IDLE: if FIFO non-empty, pop the entry into the current-byte register. Next state is S_INIT if SOT is set, else S_HI_ISSUE.
- S_INIT: `INITIALIZE`=1 for one cycle; `SYM_COUNT` cleared. Next: S_HI_ISSUE.
- S_HI_ISSUE: `EN`=1, `STRING`=byte[7:4]. Next: S_HI_WAIT.
- S_HI_WAIT: `STRING` stays stable. On `SYM_ACK`, `SYM_COUNT`++ and go to S_LO_ISSUE.
- S_LO_ISSUE: `EN`=1, `STRING`=byte[3:0]. Next: S_LO_WAIT.
- S_LO_WAIT: on `SYM_ACK`, `SYM_COUNT`++. Pulse `DONE` if EOT is set. Then:
  - if FIFO non-empty, pop the next entry immediately and go to S_INIT or S_HI_ISSUE;
  - else go to S_IDLE.
- `SYM_ACK` is ignored in S_IDLE, S_INIT and the ISSUE states. Exactly one `EN` pulse per symbol.
- `SYM_COUNT` saturates at 2^CNT_W−1 and never wraps.
- A simultaneous push and pop when the FIFO is full is impossible, because `IN_READY`=0. When not full, push and pop in the same cycle are both honoured and the occupancy is unchanged.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally. Full and empty are derived from the MSB and address comparison.

## Timing
- Reset values (cycle after `RST` sampled high): `EN`=0, `STRING`=0, `INITIALIZE`=0, `DONE`=0, `SYM_COUNT`=0, `BUSY`=0.
  - `IN_READY`=0 while `RST` is high, 1 the cycle after.
  - FIFO empty, FSM in S_IDLE.
- `RST` mid-operation discards FIFO contents and any in-flight symbol. No `EN`/`DONE` is emitted the cycle after.
- Latency, byte accepted at edge t with FSM idle:
  - without SOT: `EN` high in cycle t+2;
  - with SOT: `INITIALIZE` in t+2 and `EN` in t+3.
- Back-to-back: the next `EN` comes 1 cycle after the acknowledging `SYM_ACK` edge (ISSUE follows WAIT directly). With a 1-cycle reader, throughput is 1 symbol per 2 cycles.
- `DONE` is asserted in the same cycle as the transition out of S_LO_WAIT.

## Structure
- Shared package `ac_pkg`: `SYM_W`=4, `STATE_W`=8, `ADDR_W`=12, and the FSM state enum for `symbol_feeder`.
- Sub-module `symbol_fifo`: synchronous FIFO, parameters width/depth; ports push, pop, full, empty, data in/out.
- Top-level FSM, current-byte register and counter live in `symbol_feeder`.

## Test plan
- Reset, then push 0xA5 with SOT|EOT; reader acks 1 cycle after each `EN`.
  - Required: `INITIALIZE` at t+2; `EN`/`STRING`=0xA at t+3; `EN`/`STRING`=0x5 after ack; `DONE` once; `SYM_COUNT`=2.
- Push 9 bytes 0x00..0x08 with `IN_VALID` held and the reader stalled (no ack).
  - Required: `IN_READY` drops after 8 accepted entries (plus 1 in the current-byte register).
  - After acks resume, the symbol stream is 0,0,0,1,…,0,8 in order, with no loss or duplication.
- Ack delay randomised 1–5 cycles over 100 bytes.
  - Required: exactly 200 `EN` pulses; `STRING` stable between each `EN` and its ack; spurious acks in ISSUE states are ignored.
- Second text with SOT after 3 bytes.
  - Required: `INITIALIZE` pulses before its first `EN`; `SYM_COUNT` returns to 0, then counts 1, 2.
- Assert `RST` during S_HI_WAIT with 4 bytes queued.
  - Required: next cycle all outputs 0, `BUSY`=0; a new push then restarts with latency t+2.
- Force `SYM_COUNT` near 0xFFFF (CNT_W=16).
  - Required: it holds at 0xFFFF on further acks.

Source files
------------

// File: rtl/ac_pkg.sv
// Shared definitions for the Aho-Corasick matcher front end.
package ac_pkg;

  localparam int SYM_W   = 4;
  localparam int STATE_W = 8;
  localparam int ADDR_W  = 12;
  localparam int BYTE_W  = 2 * SYM_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_HI_ISSUE,
    S_HI_WAIT,
    S_LO_ISSUE,
    S_LO_WAIT
  } feeder_state_t;

  typedef struct packed {
    logic              sot;
    logic              eot;
    logic [BYTE_W-1:0] data;
  } fifo_entry_t;

  function automatic logic [SYM_W-1:0] hi_nibble(input logic [BYTE_W-1:0] b);
    return b[BYTE_W-1 -: SYM_W];
  endfunction

  function automatic logic [SYM_W-1:0] lo_nibble(input logic [BYTE_W-1:0] b);
    return b[SYM_W-1:0];
  endfunction

endpackage

// File: rtl/symbol_fifo.sv
// Synchronous FIFO with one extra pointer bit to tell full from empty.
module symbol_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/symbol_feeder.sv
// Byte-to-nibble issue stage feeding the table reader, one symbol per acknowledge.
//
// state      | meaning
// S_IDLE     | nothing in flight; pop head of FIFO when available
// S_INIT     | INITIALIZE pulse for a new text; symbol count cleared
// S_HI_ISSUE | EN pulse with high nibble
// S_HI_WAIT  | hold high nibble until SYM_ACK
// S_LO_ISSUE | EN pulse with low nibble
// S_LO_WAIT  | hold low nibble until SYM_ACK; DONE on EOT, pop next byte
module symbol_feeder
  import ac_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [7:0]       IN_DATA,
  input  logic             IN_SOT,
  input  logic             IN_EOT,
  output logic             EN,
  output logic [SYM_W-1:0] STRING,
  output logic             INITIALIZE,
  input  logic             SYM_ACK,
  output logic [CNT_W-1:0] SYM_COUNT,
  output logic             DONE,
  output logic             BUSY
);

  localparam int ENTRY_W = $bits(fifo_entry_t);

  feeder_state_t state;
  feeder_state_t state_nxt;
  fifo_entry_t   cur;
  fifo_entry_t   head;
  fifo_entry_t   wr_entry;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          cnt_inc;

  assign wr_entry  = '{sot: IN_SOT, eot: IN_EOT, data: IN_DATA};
  // Ready depends only on registered FIFO state and reset, never on SYM_ACK.
  assign IN_READY  = !RST && !fifo_full;
  assign fifo_push = IN_VALID && IN_READY;

  symbol_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    fifo_pop   = 1'b0;
    EN         = 1'b0;
    INITIALIZE = 1'b0;
    DONE       = 1'b0;
    STRING     = '0;
    cnt_inc    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_nxt = head.sot ? S_INIT : S_HI_ISSUE;
        end
      end
      S_INIT: begin
        INITIALIZE = 1'b1;
        state_nxt  = S_HI_ISSUE;
      end
      S_HI_ISSUE: begin
        EN        = 1'b1;
        STRING    = hi_nibble(cur.data);
        state_nxt = S_HI_WAIT;
      end
      S_HI_WAIT: begin
        STRING = hi_nibble(cur.data);
        if (SYM_ACK) begin
          cnt_inc   = 1'b1;
          state_nxt = S_LO_ISSUE;
        end
      end
      S_LO_ISSUE: begin
        EN        = 1'b1;
        STRING    = lo_nibble(cur.data);
        state_nxt = S_LO_WAIT;
      end
      S_LO_WAIT: begin
        STRING = lo_nibble(cur.data);
        if (SYM_ACK) begin
          cnt_inc = 1'b1;
          DONE    = cur.eot;
          // Chain straight into the next byte to avoid an idle bubble.
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            state_nxt = head.sot ? S_INIT : S_HI_ISSUE;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST)           cur <= '0;
    else if (fifo_pop) cur <= head;
  end

  always_ff @(posedge CLK) begin
    if (RST)                                  SYM_COUNT <= '0;
    else if (state == S_INIT)                 SYM_COUNT <= '0;
    else if (cnt_inc && (SYM_COUNT != '1))    SYM_COUNT <= SYM_COUNT + 1'b1;
  end

  assign BUSY = (state != S_IDLE) || !fifo_empty;

endmodule
